// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle MIPS-style datapath (fetch, decode, execute, memory, write-back).
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_control_unit #(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [3:0] state,
   output logic       illegal
`ifdef PERF_CNT_EN
  ,output logic [CNT_W-1:0] retired_cnt
`endif
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEM_ADR = 4'd2,
      MEM_RD  = 4'd3,
      MEM_WB  = 4'd4,
      MEM_WR  = 4'd5,
      R_EXEC  = 4'd6,
      R_WB    = 4'd7,
      BRANCH  = 4'd8,
      I_EXEC  = 4'd9,
      I_WB    = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t curState;
   state_t nextState;
   logic   illegalNext;

   assign state = curState;

   // State register and the one-cycle illegal-opcode pulse, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState <= FETCH;
         illegal  <= 1'b0;
      end else begin
         curState <= nextState;
         illegal  <= illegalNext;
      end
   end

   // Next-state logic: opcode decode in DECODE, memory handshake waits in FETCH/MEM_RD/MEM_WR.
   always_comb begin
      nextState   = FETCH;
      illegalNext = 1'b0;
      case (curState)
         FETCH:   nextState = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_R:            nextState = R_EXEC;
               OP_LW, OP_SW:    nextState = MEM_ADR;
               OP_BEQ, OP_BNE:  nextState = BRANCH;
               OP_ADDI, OP_ADDIU, OP_ANDI,
               OP_ORI, OP_SLTI, OP_SLTIU: nextState = I_EXEC;
               OP_J:            nextState = JUMP;
               default: begin
                  nextState   = FETCH;
                  illegalNext = 1'b1;
               end
            endcase
         end
         MEM_ADR: nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:  nextState = mem_ready ? MEM_WB : MEM_RD;
         MEM_WB:  nextState = FETCH;
         MEM_WR:  nextState = mem_ready ? FETCH : MEM_WR;
         R_EXEC:  nextState = R_WB;
         R_WB:    nextState = FETCH;
         BRANCH:  nextState = FETCH;
         I_EXEC:  nextState = I_WB;
         I_WB:    nextState = FETCH;
         JUMP:    nextState = FETCH;
         default: nextState = FETCH;
      endcase
   end

   // Moore output decode; fetch strobes are masked by rst_n so nothing is written while reset is held.
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      case (curState)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready & rst_n;
            pc_write  = mem_ready & rst_n;
         end
         DECODE:  alu_src_b = 2'b11;
         MEM_ADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b001;
            pc_src    = 2'b01;
            pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
         end
         I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (opcode)
               OP_ANDI:           alu_op = 3'b100;
               OP_ORI:            alu_op = 3'b101;
               OP_SLTI, OP_SLTIU: alu_op = 3'b110;
               default:           alu_op = 3'b000;
            endcase
         end
         I_WB:    reg_write = 1'b1;
         JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         default: ;
      endcase
   end

`ifdef PERF_CNT_EN
   logic retire;

   // An instruction retires when leaving a final state; stores retire only when memory completes.
   always_comb begin
      retire = 1'b0;
      case (curState)
         MEM_WB, R_WB, I_WB, BRANCH, JUMP: retire = 1'b1;
         MEM_WR:                           retire = mem_ready;
         default:                          retire = 1'b0;
      endcase
   end

   // Retired-instruction counter, wraps modulo 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired_cnt <= '0;
      else if (retire)
         retired_cnt <= retired_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an instruction-level model pushes per-cycle expected outputs, a negedge monitor compares.
// Define PERF_CNT_EN to also check the retired counter (built with CNT_W=4 to exercise wrap).
module tb_multicycle_control_unit;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic       illegal;
`ifdef PERF_CNT_EN
   logic [3:0] retired_cnt;
`endif

   multicycle_control_unit #(.CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal)
`ifdef PERF_CNT_EN
     ,.retired_cnt(retired_cnt)
`endif
   );

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] ctrl;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   typedef enum int {K_R, K_LW, K_SW, K_BR, K_I, K_J, K_BAD} kind_t;

   exp_t q[$];
   int   nChecks    = 0;
   int   nFail      = 0;
   int   modelCnt   = 0;
   logic pendingIll = 1'b0;

   wire [15:0] actCtrl = {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                          reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so a hung FSM cannot stall the run forever.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [15:0] ctl(input logic pw, input logic [1:0] ps, input logic io,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop);
      return {pw, ps, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop};
   endfunction

   function automatic kind_t kindOf(input logic [5:0] op);
      case (op)
         6'b000000:                       return K_R;
         6'b100011:                       return K_LW;
         6'b101011:                       return K_SW;
         6'b000100, 6'b000101:            return K_BR;
         6'b001000, 6'b001001, 6'b001100,
         6'b001101, 6'b001010, 6'b001011: return K_I;
         6'b000010:                       return K_J;
         default:                         return K_BAD;
      endcase
   endfunction

   // Drive one cycle's inputs, record what the outputs must be during it, then advance.
   task automatic applyStimulus(input logic [3:0] st, input logic [15:0] c,
                                input logic mr, input logic z, input logic retire);
      exp_t e;
      mem_ready = mr;
      zero      = z;
      e.st   = st;
      e.ctrl = c;
      e.ill  = pendingIll;
      e.cnt  = 32'(modelCnt);
      q.push_back(e);
      pendingIll = 1'b0;
      @(posedge clk);
      #1;
      if (retire) modelCnt++;
   endtask

   // One whole instruction; zf < 0 picks the zero flag at random.
   task automatic runInstr(input logic [5:0] op, input int fetchWaits, input int memWaits,
                           input int zf);
      logic       z;
      logic [2:0] iop;
      for (int i = 0; i < fetchWaits; i++)
         applyStimulus(4'd0, ctl(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000), 1'b0, rb(), 1'b0);
      applyStimulus(4'd0, ctl(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000), 1'b1, rb(), 1'b0);
      opcode = op;
      applyStimulus(4'd1, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000), rb(), rb(), 1'b0);
      case (kindOf(op))
         K_R: begin
            applyStimulus(4'd6, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010), rb(), rb(), 1'b0);
            applyStimulus(4'd7, ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000), rb(), rb(), 1'b1);
         end
         K_LW: begin
            applyStimulus(4'd2, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000), rb(), rb(), 1'b0);
            for (int i = 0; i < memWaits; i++)
               applyStimulus(4'd3, ctl(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000), 1'b0, rb(), 1'b0);
            applyStimulus(4'd3, ctl(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000), 1'b1, rb(), 1'b0);
            applyStimulus(4'd4, ctl(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000), rb(), rb(), 1'b1);
         end
         K_SW: begin
            applyStimulus(4'd2, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000), rb(), rb(), 1'b0);
            for (int i = 0; i < memWaits; i++)
               applyStimulus(4'd5, ctl(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000), 1'b0, rb(), 1'b0);
            applyStimulus(4'd5, ctl(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000), 1'b1, rb(), 1'b1);
         end
         K_BR: begin
            z = (zf < 0) ? rb() : 1'(zf);
            applyStimulus(4'd8, ctl((op == 6'b000100) ? z : !z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1,
                                    2'b00, 3'b001), rb(), z, 1'b1);
         end
         K_I: begin
            if (op == 6'b001100)      iop = 3'b100;
            else if (op == 6'b001101) iop = 3'b101;
            else if (op == 6'b001010 || op == 6'b001011) iop = 3'b110;
            else                      iop = 3'b000;
            applyStimulus(4'd9, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, iop), rb(), rb(), 1'b0);
            applyStimulus(4'd10, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000), rb(), rb(), 1'b1);
         end
         K_J:
            applyStimulus(4'd11, ctl(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000), rb(), rb(), 1'b1);
         default:
            pendingIll = 1'b1;
      endcase
   endtask

   // Outputs held by an asserted reset: fetch decode with the strobes masked.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_state"}, 32'(state), 32'd0);
      checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'd1);
      checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'd0);
      checkOutput({tag, "_ir_write"}, 32'(ir_write), 32'd0);
      checkOutput({tag, "_pc_write"}, 32'(pc_write), 32'd0);
      checkOutput({tag, "_illegal"}, 32'(illegal), 32'd0);
`ifdef PERF_CNT_EN
      checkOutput({tag, "_retired"}, 32'(retired_cnt), 32'd0);
`endif
   endtask

   // Negedge monitor: compare the DUT against the next queued expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checkOutput("state", 32'(state), 32'(e.st));
         checkOutput("ctrl", 32'(actCtrl), 32'(e.ctrl));
         checkOutput("illegal", 32'(illegal), 32'(e.ill));
`ifdef PERF_CNT_EN
         checkOutput("retired", 32'(retired_cnt), 32'(e.cnt[3:0]));
`endif
      end
   end

   // Main sequence: directed instructions, random mix, then asynchronous reset mid-store.
   initial begin
      logic [5:0] legalOps [13];
      logic [5:0] op;
      legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b001001,
                   6'b001100, 6'b001101, 6'b001010, 6'b001011, 6'b000010, 6'b000000};
      rst_n     = 1'b0;
      opcode    = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst_n = 1'b1;

      runInstr(6'b000000, 0, 0, -1);
      runInstr(6'b100011, 0, 2, -1);
      runInstr(6'b000100, 0, 0, 1);
      runInstr(6'b000101, 0, 0, 1);
      runInstr(6'b000100, 1, 0, 0);
      runInstr(6'b001101, 0, 0, -1);
      runInstr(6'b111111, 0, 0, -1);
      runInstr(6'b001100, 0, 0, -1);
      runInstr(6'b101011, 2, 1, -1);
      runInstr(6'b000010, 0, 0, -1);
      for (int i = 0; i < 16; i++)
         runInstr(6'b000000, 0, 0, -1);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 7) == 0)
            op = 6'($urandom);
         else
            op = legalOps[$urandom_range(0, 12)];
         runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end

      runInstr(6'b000000, 0, 0, -1);
      applyStimulus(4'd0, ctl(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000), 1'b1, rb(), 1'b0);
      opcode = 6'b101011;
      applyStimulus(4'd1, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000), rb(), rb(), 1'b0);
      applyStimulus(4'd2, ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000), rb(), rb(), 1'b0);
      mem_ready = 1'b0;
      q.push_back('{st: 4'd5, ctrl: ctl(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000),
                    ill: 1'b0, cnt: 32'(modelCnt)});
      #5;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      checkResetOutputs("async_reset");
      @(posedge clk);
      #1;
      checkResetOutputs("held_reset");
      rst_n      = 1'b1;
      modelCnt   = 0;
      pendingIll = 1'b0;

      runInstr(6'b000000, 0, 0, -1);
      runInstr(6'b000010, 0, 0, -1);

      @(negedge clk);
      #1;
      checkOutput("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter (used only with PERF_CNT_EN).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instr[31:26] from IR; stable except after an IR write.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake; access completes in a cycle where it is high.
REQ-007 pc_write  output  1  PC load enable.
REQ-008 pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-009 iord, mem_read, mem_write, ir_write  output  1 each  memory address select (0 PC, 1 ALUOut) and strobes.
REQ-010 reg_dst, mem_to_reg, reg_write  output  1 each  register-file write controls (reg_dst 1 = rd).
REQ-011 alu_src_a  output  1  0 PC, 1 reg A; alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-012 alu_op  output  3  000 add, 001 sub, 010 R-type (decode by func), 100 and, 101 or, 110 slt; feeds ALU control.
REQ-013 state  output  4  current state; illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-014 retired_cnt  output  CNT_W  retired-instruction count (present only with PERF_CNT_EN).

Function
REQ-015 The block SHALL be a Moore FSM, states: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-016 Every control output not listed for a state SHALL be 0 (alu_op 000, pc_src 00).
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000; ir_write=pc_write=1 only while mem_ready=1; stay until mem_ready=1, then DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; next: 000000->R_EXEC; 100011/101011->MEM_ADR; 000100/000101->BRANCH; 001000/001001/001100/001101/001010/001011->I_EXEC; 000010->JUMP; any other->FETCH with illegal=1 for that one cycle.
REQ-019 MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=000; lw->MEM_RD, sw->MEM_WR.
REQ-020 MEM_RD: iord=1, mem_read=1; wait for mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-021 MEM_WR: iord=1, mem_write=1; wait for mem_ready, then FETCH.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; ->R_WB. R_WB: reg_write=1, reg_dst=1; ->FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01; pc_write=zero for beq, ~zero for bne (combinational on zero); ->FETCH.
REQ-024 I_EXEC: alu_src_a=1, alu_src_b=10; alu_op 000 addi/addiu, 100 andi, 101 ori, 110 slti/sltiu; ->I_WB. I_WB: reg_write=1, reg_dst=0; ->FETCH.
REQ-025 JUMP: pc_write=1, pc_src=10; ->FETCH.
REQ-026 Latency: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3, each plus one cycle per memory wait cycle.

Reset
REQ-027 rst_n low SHALL immediately force state=FETCH, illegal=0, retired_cnt=0, independent of clk.
REQ-028 While in reset, control outputs SHALL equal FETCH decode with mem_ready masked: mem_read=1, ir_write=pc_write=0; reset mid-instruction SHALL abandon it with no write strobe.
REQ-029 First post-reset rising edge with mem_ready=1 SHALL complete a fetch.

Configuration
REQ-030 PERF_CNT_EN defined: retired_cnt SHALL increment by 1 on each exit from MEM_WB, R_WB, I_WB, BRANCH, JUMP, and MEM_WR with mem_ready=1; wraps modulo 2^CNT_W; illegal opcodes do not count.
REQ-031 PERF_CNT_EN undefined: retired_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; alu_op=010 in R_EXEC; reg_write=reg_dst=1 in R_WB.
REQ-033 lw (100011), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, MEM_WB mem_to_reg=1, total 7 cycles.
REQ-034 beq zero=1 -> pc_write=1, pc_src=01; bne zero=1 -> pc_write=0; both alu_op=001.
REQ-035 opcode=001101 (ori) -> alu_op=101 in I_EXEC; opcode=111111 -> illegal pulse 1 cycle, return to FETCH, retired_cnt unchanged.
REQ-036 rst_n low during MEM_WR -> state=0 asynchronously, mem_write=0; PERF_CNT_EN, CNT_W=4, 16 R-types -> retired_cnt wraps to 0.
